// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared constants and types for the multiply/divide
// writeback injector.
//   - Instruction decode fields (R-type opcode, MULT/DIV ALU ops).
//   - FSM state encoding.
//   - Exception injection constants (rstatus register and cause codes),
//     used only when MULTDIV_EXCEPTION_EN is defined.
package multdiv_pkg;

  localparam logic [4:0]  OPC_RTYPE   = 5'b00000;
  localparam logic [4:0]  ALUOP_MULT  = 5'b00110;
  localparam logic [4:0]  ALUOP_DIV   = 5'b00111;

  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] EXC_MULT    = 32'd4;
  localparam logic [31:0] EXC_DIV     = 32'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's complement magnitude; 0x80000000 maps to itself, which reads
  // correctly as the unsigned magnitude 2^31.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_datapath.sv
// multdiv_datapath: unsigned iterative engine, one bit per step.
//   MULT: shift/add. r_lo holds the multiplier and collects the low product
//         half as it shifts right; r_hi accumulates the high half.
//   DIV : restoring division. {r_hi, r_lo} shifts left; r_hi is the partial
//         remainder, r_lo the dividend turning into the quotient.
// Ports:
//   clock, reset      clock, async active-low reset
//   i_load            load operands and clear the counter
//   i_load_mc         multiplicand (MULT) or divisor (DIV) magnitude
//   i_load_lo         multiplier (MULT) or dividend (DIV) magnitude
//   i_op_div          1 = divide step, 0 = multiply step
//   i_step            advance one iteration
//   o_last            counter is at CYCLES-1 (this step is the final one)
//   o_hi_nxt/o_lo_nxt register values after the current step; on the final
//                     step this is the full product or {rem, quotient}
//   o_mc_zero         loaded divisor is zero
module multdiv_datapath #(
  parameter int CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_load_mc,
  input  logic [31:0] i_load_lo,
  input  logic        i_op_div,
  input  logic        i_step,
  output logic        o_last,
  output logic [31:0] o_hi_nxt,
  output logic [31:0] o_lo_nxt,
  output logic        o_mc_zero
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_mc;
  logic [CW-1:0] r_cnt;

  logic [32:0]   w_sum;
  logic [32:0]   w_sh;
  logic [33:0]   w_diff;
  logic          w_qbit;
  logic          w_unused;

  always_comb begin
    // multiply: add multiplicand when the current multiplier bit is set,
    // then shift the 65-bit {carry, hi, lo} right by one
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mc} : 33'd0);
    // divide: shift remainder left pulling in next dividend bit, try subtract
    w_sh   = {r_hi, r_lo[31]};
    w_diff = {1'b0, w_sh} - {2'b00, r_mc};
    w_qbit = ~w_diff[33];
    if (i_op_div) begin
      // remainder stays below the divisor (<= 2^31), so 32 bits hold it
      o_hi_nxt = w_qbit ? w_diff[31:0] : w_sh[31:0];
      o_lo_nxt = {r_lo[30:0], w_qbit};
    end else begin
      o_hi_nxt = w_sum[32:1];
      o_lo_nxt = {w_sum[0], r_lo[31:1]};
    end
  end

  assign o_last    = (r_cnt == CW'(CYCLES - 1));
  assign o_mc_zero = (r_mc == 32'd0);
  assign w_unused  = ^{w_diff[32], w_sh[32]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_mc  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_load_lo;
      r_mc  <= i_load_mc;
      r_cnt <= '0;
    end else if (i_step) begin
      r_hi  <= o_hi_nxt;
      r_lo  <= o_lo_nxt;
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/multdiv_writeback.sv
// multdiv_writeback: captures MULT/DIV leaving D/X, runs the iterative
// engine while stalling issue, then injects the result into writeback
// through a valid/ready port.
// Configuration macro: MULTDIV_EXCEPTION_EN
//   defined   -> MULT overflow, DIV overflow and divide-by-zero redirect the
//                write to rstatus (r30) with cause 4 (MULT) / 5 (DIV)
//   undefined -> overflowing MULT writes the low 32 bits, DIV by zero
//                writes 0; no exception flags exist
// Ports:
//   clock, reset   pipeline clock, async active-low reset
//   dx_irin        instruction leaving D/X
//   dx_a, dx_b     bypassed rs / rt operands
//   issue_enable   X/M write enable; capture only when high
//   stall          freeze PC, F/D, D/X
//   wb_valid       result available (DONE state)
//   wb_ready       writeback port free this cycle
//   wb_rd, wb_data destination register and value, stable while wb_valid
module multdiv_writeback
  import multdiv_pkg::*;
#(
  parameter int CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_irin,
  input  logic [31:0] dx_a,
  input  logic [31:0] dx_b,
  input  logic        issue_enable,
  output logic        stall,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_div;
  logic        r_neg;
  logic [4:0]  r_rd;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
`ifdef MULTDIV_EXCEPTION_EN
  logic        r_div0;
  logic        w_mul_ovf;
  logic        w_div_ovf;
`endif

  logic        w_match;
  logic        w_is_div;
  logic        w_retire;
  logic        w_start;
  logic        w_step;
  logic        w_finish;
  logic        w_last;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic        w_mc_zero;
  logic [63:0] w_prod_mag;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [4:0]  w_res_rd;
  logic [31:0] w_res_data;
  logic        w_unused;

  // Same match as the X/M squash: anything squashed there is owned here.
  assign w_is_div = (dx_irin[6:2] == ALUOP_DIV);
  assign w_match  = (dx_irin[31:27] == OPC_RTYPE) &&
                    ((dx_irin[6:2] == ALUOP_MULT) || w_is_div);

  // A waiting MULT/DIV is taken on the retire edge so stall never dips
  // between back-to-back operations.
  assign w_retire = (r_state == DONE) && wb_ready;
  assign w_start  = issue_enable && w_match &&
                    ((r_state == IDLE) || w_retire);
  assign w_finish = (r_state == BUSY) && w_last;

  // ---- FSM: state register ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = BUSY;
      BUSY:    if (w_last)  w_state_nxt = DONE;
      DONE:    if (wb_ready) w_state_nxt = w_start ? BUSY : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    stall    = (r_state != IDLE) || w_start;
    wb_valid = (r_state == DONE);
    w_step   = (r_state == BUSY);
  end

  // ---- capture ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_div  <= 1'b0;
      r_neg  <= 1'b0;
      r_rd   <= '0;
`ifdef MULTDIV_EXCEPTION_EN
      r_div0 <= 1'b0;
`endif
    end else if (w_start) begin
      r_div  <= w_is_div;
      r_neg  <= dx_a[31] ^ dx_b[31];
      r_rd   <= dx_irin[26:22];
`ifdef MULTDIV_EXCEPTION_EN
      r_div0 <= w_is_div && (dx_b == 32'd0);
`endif
    end
  end

  multdiv_datapath #(.CYCLES(CYCLES)) u_dp (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_start),
    .i_load_mc (w_is_div ? mag32(dx_b) : mag32(dx_a)),
    .i_load_lo (w_is_div ? mag32(dx_a) : mag32(dx_b)),
    .i_op_div  (r_div),
    .i_step    (w_step),
    .o_last    (w_last),
    .o_hi_nxt  (w_hi_nxt),
    .o_lo_nxt  (w_lo_nxt),
    .o_mc_zero (w_mc_zero)
  );

  // ---- sign fixup on the final step ----
  always_comb begin
    w_prod_mag = {w_hi_nxt, w_lo_nxt};
    w_prod     = r_neg ? (~w_prod_mag + 64'd1) : w_prod_mag;
    w_quo      = r_neg ? (~w_lo_nxt + 32'd1) : w_lo_nxt;
    w_res_rd   = r_rd;
`ifdef MULTDIV_EXCEPTION_EN
    w_mul_ovf  = (w_prod[63:32] != {32{w_prod[31]}});
    // a positive quotient with bit 31 set only comes from 0x80000000 / -1
    // (or the all-ones quotient of a zero divisor, already an exception)
    w_div_ovf  = ~r_neg && w_lo_nxt[31];
    if (r_div) begin
      if (r_div0 || w_div_ovf) begin
        w_res_rd   = RSTATUS_REG;
        w_res_data = EXC_DIV;
      end else begin
        w_res_data = w_quo;
      end
    end else begin
      if (w_mul_ovf) begin
        w_res_rd   = RSTATUS_REG;
        w_res_data = EXC_MULT;
      end else begin
        w_res_data = w_prod[31:0];
      end
    end
`else
    if (r_div) w_res_data = w_mc_zero ? 32'd0 : w_quo;
    else       w_res_data = w_prod[31:0];
`endif
  end

`ifdef MULTDIV_EXCEPTION_EN
  assign w_unused = ^{dx_irin[21:7], dx_irin[1:0], w_mc_zero};
`else
  assign w_unused = ^{dx_irin[21:7], dx_irin[1:0], w_prod[63:32]};
`endif

  // ---- result registers: written once per op, held through DONE ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else if (w_finish) begin
      r_wb_rd   <= w_res_rd;
      r_wb_data <= w_res_data;
    end
  end

  assign wb_rd   = r_wb_rd;
  assign wb_data = r_wb_data;

endmodule
